// File: rtl/display_scan_ctrl_pkg.sv
// ==========================================================================
// display_scan_ctrl_pkg -- scan FSM encodings and display constants
// Rev 1.0
// ==========================================================================
`default_nettype none

package display_scan_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [6:0] SEG_OFF = 7'b0;

endpackage

`default_nettype wire

// File: rtl/display_scan_ctrl_bcd_digit.sv
// ==========================================================================
// bcd_digit -- one decade of the BCD counter, combinational carry out
// Rev 1.0
// ==========================================================================
`default_nettype none

module bcd_digit
  import display_scan_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       cin,
  output logic [3:0] q,
  output logic       cout
);

  assign cout = cin && (q == BCD_MAX);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= 4'd0;
    end else if (cin) begin
      q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/display_scan_ctrl_seg7.sv
// ==========================================================================
// seg7 -- BCD to seven-segment decoder (gfedcba, 1 = lit)
// Rev 1.0
// ==========================================================================
`default_nettype none

module seg7
  import display_scan_ctrl_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (digit)
      4'd0: seg = 7'h3F;
      4'd1: seg = 7'h06;
      4'd2: seg = 7'h5B;
      4'd3: seg = 7'h4F;
      4'd4: seg = 7'h66;
      4'd5: seg = 7'h6D;
      4'd6: seg = 7'h7D;
      4'd7: seg = 7'h07;
      4'd8: seg = 7'h7F;
      4'd9: seg = 7'h6F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/display_scan_ctrl.sv
// ==========================================================================
// display_scan_ctrl -- multi-digit BCD counter with multiplexed 7-seg scan
// Rev 1.0
// ==========================================================================
`default_nettype none

module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 2500,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inc,
  input  logic                    clr,
  input  logic                    lzb_en,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic                    overflow
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  scan_state_t           state, state_n;
  logic [IW-1:0]         idx, idx_n;
  logic [CW-1:0]         slot_cnt, slot_cnt_n;
  logic [NUM_DIGITS:0]   carry;
  logic [3:0]            digit_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] suppress;
  logic [3:0]            sel_digit;
  logic [6:0]            seg_dec;
  logic [NUM_DIGITS-1:0] an_n;
  logic [6:0]            seg_n;

  assign carry[0] = inc;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .cin   (carry[i]),
      .q     (digit_q[i]),
      .cout  (carry[i+1])
    );
    assign count_bcd[4*i +: 4] = digit_q[i];

    // A digit is a leading zero when it and every more significant digit are 0.
    if (i == 0) begin : g_lsd
      assign suppress[i] = 1'b0;
    end else begin : g_upper
      assign suppress[i] = lzb_en && (count_bcd[4*NUM_DIGITS-1:4*i] == '0);
    end
  end

  // Decode from the next slot index so anode and segments land in the same cycle.
  assign sel_digit = digit_q[idx_n];

  seg7 u_seg7 (
    .digit (sel_digit),
    .seg   (seg_dec)
  );

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    slot_cnt_n = slot_cnt + 1'b1;
    case (state)
      ST_BLANK: begin
        if (slot_cnt == BLANK_LAST) begin
          state_n = ST_SHOW;
          idx_n   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
      end
      ST_SHOW: begin
        if (slot_cnt == SLOT_LAST) begin
          state_n    = ST_BLANK;
          slot_cnt_n = '0;
        end
      end
    endcase

    an_n  = '0;
    seg_n = SEG_OFF;
    if (state_n == ST_SHOW && !suppress[idx_n]) begin
      an_n  = NUM_DIGITS'(1) << idx_n;
      seg_n = seg_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_BLANK;
      idx      <= IDX_LAST;
      slot_cnt <= '0;
      an_out   <= '0;
      seg_out  <= SEG_OFF;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      slot_cnt <= slot_cnt_n;
      an_out   <= an_n;
      seg_out  <= seg_n;
      overflow <= carry[NUM_DIGITS] && !clr;
    end
  end

endmodule

`default_nettype wire
